// File: rtl/result_str_pkg.sv
// Shared definitions for the result streaming path: cfg register map and
// small sizing helpers used by the serializer.
package result_str_pkg;

    localparam int CFG_KER_WR = 0;
    localparam int CFG_KER_RD = 1;
    localparam int CFG_RES_WR = 2;

    // Counter width for a given number of beats; never narrower than 1 bit.
    function automatic int beat_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/result_str_res_serializer.sv
// Wide-to-narrow shift register: emits a captured word as IN_WIDTH/OUT_WIDTH
// beats, least-significant slice first, with last passed through on the final beat.
module res_serializer
    import result_str_pkg::*;
#(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_fire,
    input  logic                 out_val,
    input  logic                 out_rdy,
    input  logic                 last_word,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 final_beat
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int BW    = beat_width(RATIO);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    logic [IN_WIDTH-1:0] shift_reg;
    logic [BW-1:0]       beat_cnt_reg;
    logic                out_fire;

    assign out_fire   = out_val && out_rdy;
    assign final_beat = (beat_cnt_reg == LAST_BEAT);
    assign out_data   = shift_reg[OUT_WIDTH-1:0];
    assign out_last   = out_val && final_beat && last_word;

    // A capture on the final beat takes priority over the shift so the next
    // word follows without a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_reg    <= '0;
            beat_cnt_reg <= '0;
        end else if (in_fire) begin
            shift_reg    <= in_data;
            beat_cnt_reg <= '0;
        end else if (out_fire) begin
            shift_reg    <= shift_reg >> OUT_WIDTH;
            beat_cnt_reg <= final_beat ? '0 : beat_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/result_str.sv
// Result streamer: cfg-programmed word count, FSM and word counter around a
// wide-to-narrow serializer feeding the outbound result stream.
module result_str
    import result_str_pkg::*;
#(
    parameter int CFG_DWIDTH    = 32,
    parameter int CFG_AWIDTH    = 5,
    parameter int STR_RES_WIDTH = 64,
    parameter int GROUP_NB      = 4,
    parameter int RES_WIDTH     = 32,
    parameter int LANE_NB       = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CFG_DWIDTH-1:0]                  cfg_data,
    input  logic [CFG_AWIDTH-1:0]                  cfg_addr,
    input  logic                                   cfg_valid,
    input  logic [GROUP_NB*RES_WIDTH*LANE_NB-1:0]  res_bus,
    input  logic                                   res_val,
    output logic                                   res_rdy,
    output logic [STR_RES_WIDTH-1:0]               str_res,
    output logic                                   str_res_val,
    output logic                                   str_res_last,
    input  logic                                   str_res_rdy,
    output logic                                   busy
);

    localparam int RES_BUS = GROUP_NB * RES_WIDTH * LANE_NB;
    localparam int RATIO   = RES_BUS / STR_RES_WIDTH;

    generate
        if ((RES_BUS % STR_RES_WIDTH) != 0 || RATIO < 1) begin : g_bad_ratio
            $error("result_str: RES_BUS must be a positive multiple of STR_RES_WIDTH");
        end
        if (CNT_WIDTH > CFG_DWIDTH) begin : g_bad_cnt
            $error("result_str: CNT_WIDTH must not exceed CFG_DWIDTH");
        end
        if (CNT_WIDTH < CFG_DWIDTH) begin : g_cfg_upper
            logic cfg_upper_unused;
            assign cfg_upper_unused = ^cfg_data[CFG_DWIDTH-1:CNT_WIDTH];
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] word_cnt_reg, word_cnt_next;
    logic [CNT_WIDTH-1:0] word_end_reg, word_end_next;
    logic                 cfg_wr;
    logic                 last_word;
    logic                 final_beat;
    logic                 beat_fire;
    logic                 res_fire;

    assign cfg_wr      = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_RES_WR));
    assign last_word   = (word_cnt_reg == word_end_reg);
    assign str_res_val = (state_reg == SHIFT);
    assign beat_fire   = str_res_val && str_res_rdy;
    assign res_fire    = res_rdy && res_val;
    assign busy        = (state_reg != IDLE);

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        word_end_next = word_end_reg;
        res_rdy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cfg_wr) begin
                    word_end_next = cfg_data[CNT_WIDTH-1:0];
                    word_cnt_next = '0;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                res_rdy = 1'b1;
                if (res_val) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Final beat of a non-final word reopens the input in the same cycle.
                if (beat_fire && final_beat) begin
                    if (last_word) begin
                        state_next = IDLE;
                    end else begin
                        res_rdy       = 1'b1;
                        word_cnt_next = word_cnt_reg + 1'b1;
                        state_next    = res_val ? SHIFT : LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            word_cnt_reg <= '0;
            word_end_reg <= '0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            word_end_reg <= word_end_next;
        end
    end

    res_serializer #(
        .IN_WIDTH  (RES_BUS),
        .OUT_WIDTH (STR_RES_WIDTH)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .in_data    (res_bus),
        .in_fire    (res_fire),
        .out_val    (str_res_val),
        .out_rdy    (str_res_rdy),
        .last_word  (last_word),
        .out_data   (str_res),
        .out_last   (str_res_last),
        .final_beat (final_beat)
    );

endmodule

// File: tb/tb_result_str.sv
// Randomized bench for result_str: a transaction-level scoreboard expands each
// accepted word into its expected beats and checks stream, ready and busy.
module tb_result_str;
    import result_str_pkg::*;

    localparam int CFG_DWIDTH = 32;
    localparam int CFG_AWIDTH = 5;
    localparam int W          = 64;
    localparam int RB         = 256;
    localparam int RATIO      = RB / W;
    localparam int CNT_WIDTH  = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [CFG_DWIDTH-1:0] cfg_data = '0;
    logic [CFG_AWIDTH-1:0] cfg_addr = '0;
    logic                  cfg_valid = 1'b0;
    logic [RB-1:0]         res_bus = '0;
    logic                  res_val = 1'b0;
    logic                  res_rdy;
    logic [W-1:0]          str_res;
    logic                  str_res_val;
    logic                  str_res_last;
    logic                  str_res_rdy = 1'b0;
    logic                  busy;

    always #5 clk = ~clk;

    result_str #(
        .CFG_DWIDTH    (CFG_DWIDTH),
        .CFG_AWIDTH    (CFG_AWIDTH),
        .STR_RES_WIDTH (W),
        .GROUP_NB      (4),
        .RES_WIDTH     (32),
        .LANE_NB       (2),
        .CNT_WIDTH     (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_data     (cfg_data),
        .cfg_addr     (cfg_addr),
        .cfg_valid    (cfg_valid),
        .res_bus      (res_bus),
        .res_val      (res_val),
        .res_rdy      (res_rdy),
        .str_res      (str_res),
        .str_res_val  (str_res_val),
        .str_res_last (str_res_last),
        .str_res_rdy  (str_res_rdy),
        .busy         (busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard state, written only by the monitor below.
    logic [W-1:0] exp_data_q[$];
    bit           exp_last_q[$];
    bit           m_active = 0;
    int           m_end    = 0;
    int           m_words  = 0;
    int           words_accepted_total = 0;
    int           beats_total    = 0;
    int           transfers_done = 0;
    bit           stall_prev = 0;
    logic [W-1:0] data_prev  = '0;
    logic         last_prev  = 1'b0;

    always @(negedge clk) begin
        bit owed;
        bit popped_last;
        owed = m_active && (m_words <= m_end);
        check_val("busy", W'(busy), W'(m_active));
        check_val("str_res_val", W'(str_res_val), W'(exp_data_q.size() != 0));
        check_val("res_rdy", W'(res_rdy),
                  W'(owed && (exp_data_q.size() == 0 || (exp_data_q.size() == 1 && str_res_rdy))));
        if (!str_res_val)
            check_val("last_idle", W'(str_res_last), '0);
        if (stall_prev) begin
            check_val("stall_data", str_res, data_prev);
            check_val("stall_last", W'(str_res_last), W'(last_prev));
        end
        if (str_res_val && exp_data_q.size() != 0) begin
            check_val("beat_data", str_res, exp_data_q[0]);
            check_val("beat_last", W'(str_res_last), W'(exp_last_q[0]));
        end

        if (!rst) begin
            exp_data_q.delete();
            exp_last_q.delete();
            m_active   = 0;
            m_words    = 0;
            stall_prev = 0;
        end else begin
            stall_prev  = str_res_val && !str_res_rdy;
            data_prev   = str_res;
            last_prev   = str_res_last;
            popped_last = 0;
            if (str_res_val && str_res_rdy && exp_data_q.size() != 0) begin
                beats_total++;
                popped_last = exp_last_q.pop_front();
                void'(exp_data_q.pop_front());
            end
            if (res_val && res_rdy) begin
                for (int i = 0; i < RATIO; i++) begin
                    exp_data_q.push_back(res_bus[i*W +: W]);
                    exp_last_q.push_back((i == RATIO - 1) && (m_words == m_end));
                end
                m_words++;
                words_accepted_total++;
            end
            if (popped_last) begin
                m_active = 0;
                transfers_done++;
                $display("[TB] transfer %0d complete: %0d words, %0d beats total",
                         transfers_done, m_end + 1, beats_total);
            end else if (!m_active && cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_RES_WR)) begin
                m_active = 1;
                m_end    = int'(cfg_data[CNT_WIDTH-1:0]);
                m_words  = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_word(input bit fixed);
        if (fixed)
            res_bus = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        else
            for (int i = 0; i < RB / 32; i++) res_bus[i*32 +: 32] = $urandom;
    endtask

    // rdy_mode: 0 always ready, 1 toggling, 2 random with rdy_pct.
    task automatic run_transfer(input int wend, input int val_pct, input int rdy_mode,
                                input int rdy_pct, input int gap, input int mid_cfg,
                                input bit fixed, input bit noise);
        int  start_done;
        int  seen;
        int  cyc;
        int  gap_left;
        bit  first;
        bit  tog;
        logic [CFG_AWIDTH-1:0] naddr;
        start_done = transfers_done;
        seen       = words_accepted_total;
        cyc        = 0;
        gap_left   = 0;
        first      = 1;
        tog        = 1;
        new_word(fixed);
        cfg_valid = 1'b1;
        cfg_addr  = CFG_AWIDTH'(CFG_RES_WR);
        cfg_data  = ($urandom & 32'hFFFF_0000) | 32'(wend);
        tick();
        while (transfers_done == start_done && cyc < 3000) begin
            if (words_accepted_total != seen) begin
                seen = words_accepted_total;
                new_word(0);
                if (first && gap > 0) gap_left = gap;
                first = 0;
            end
            res_val = (gap_left > 0) ? 1'b0 : ($urandom_range(0, 99) < val_pct);
            if (gap_left > 0) gap_left--;
            case (rdy_mode)
                0:       str_res_rdy = 1'b1;
                1:       begin str_res_rdy = tog; tog = !tog; end
                default: str_res_rdy = ($urandom_range(0, 99) < rdy_pct);
            endcase
            if (cyc == mid_cfg) begin
                cfg_valid = 1'b1;
                cfg_addr  = CFG_AWIDTH'(CFG_RES_WR);
                cfg_data  = 32'd7;
            end else if (noise && $urandom_range(0, 5) == 0) begin
                naddr = CFG_AWIDTH'($urandom_range(0, 31));
                if (naddr == CFG_AWIDTH'(CFG_RES_WR)) naddr = CFG_AWIDTH'(CFG_KER_WR);
                cfg_valid = 1'b1;
                cfg_addr  = naddr;
                cfg_data  = $urandom;
            end else begin
                cfg_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        check_val("xfer_done", W'(transfers_done != start_done), W'(1));
        res_val   = 1'b0;
        cfg_valid = 1'b0;
        tick();
    endtask

    task automatic reset_mid_transfer();
        int b0;
        int cyc;
        int seen;
        b0   = beats_total;
        seen = words_accepted_total;
        cyc  = 0;
        new_word(0);
        str_res_rdy = 1'b1;
        cfg_valid = 1'b1;
        cfg_addr  = CFG_AWIDTH'(CFG_RES_WR);
        cfg_data  = 32'd3;
        tick();
        cfg_valid = 1'b0;
        res_val   = 1'b1;
        while (beats_total - b0 < 2 && cyc < 100) begin
            tick();
            if (words_accepted_total != seen) res_val = 1'b0;
            cyc++;
        end
        check_val("rst_reach_beat2", W'(beats_total - b0), W'(2));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_val("rst_str_res", str_res, '0);
        check_val("rst_val", W'(str_res_val), '0);
        check_val("rst_last", W'(str_res_last), '0);
        check_val("rst_res_rdy", W'(res_rdy), '0);
        check_val("rst_busy", W'(busy), '0);
        tick();
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        check_val("reset_str_res", str_res, '0);
        check_val("reset_val", W'(str_res_val), '0);
        check_val("reset_last", W'(str_res_last), '0);
        check_val("reset_res_rdy", W'(res_rdy), '0);
        check_val("reset_busy", W'(busy), '0);
        rst = 1'b1;
        tick();

        run_transfer(0, 100, 0, 100, 0, -1, 1, 0);
        run_transfer(2, 100, 0, 100, 0, -1, 0, 0);
        run_transfer(1, 100, 1, 100, 0, -1, 0, 0);
        run_transfer(0, 100, 0, 100, 0, 3, 0, 0);
        check_val("after_busy_cfg_res_rdy", W'(res_rdy), '0);
        check_val("after_busy_cfg_busy", W'(busy), '0);
        run_transfer(1, 100, 0, 100, 5, -1, 0, 0);
        reset_mid_transfer();
        run_transfer(1, 100, 0, 100, 0, -1, 0, 0);

        for (int t = 0; t < 20; t++) begin
            run_transfer($urandom_range(0, 5), $urandom_range(30, 100), 2,
                         $urandom_range(30, 100), 0, -1, 0, 1);
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/result_str.md
Name: result_str

Overview:
- Output-side counterpart of the kernel weight loader: takes wide result words from the compute array and serializes them onto the narrow outbound result stream to the host/DMA.
- The cfg bus sets the number of words per transfer.
- Asserts str_res_last on the final beat of the final word, then returns to idle.
- Sits between the compute pipeline output and the top-level streaming port.

Parameters:
- CFG_DWIDTH, 32, cfg bus data width
- CFG_AWIDTH, 5, cfg bus address width
- STR_RES_WIDTH, 64, outbound stream beat width
- GROUP_NB, 4, number of result groups in a wide word
- RES_WIDTH, 32, bits per result element
- LANE_NB, 2, elements per group
- CNT_WIDTH, 16, word-count width; must be ≤ CFG_DWIDTH
- Derived: RES_BUS = GROUP_NB*RES_WIDTH*LANE_NB (256). RATIO = RES_BUS/STR_RES_WIDTH (4). RES_BUS must be an integer multiple of STR_RES_WIDTH and RATIO ≥ 1; elaboration fails otherwise.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (rst==0 resets)
- cfg_data  in  CFG_DWIDTH  cfg payload
- cfg_addr  in  CFG_AWIDTH  cfg register address
- cfg_valid  in  1  cfg write strobe
- res_bus  in  RES_BUS  wide result word
- res_val  in  1  res_bus valid
- res_rdy  out  1  block accepts res_bus
- str_res  out  STR_RES_WIDTH  outbound beat
- str_res_val  out  1  beat valid
- str_res_last  out  1  final beat of transfer
- str_res_rdy  in  1  downstream ready
- busy  out  1  transfer configured and not yet complete

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; all outputs 0.
  - Shift register, beat counter and word counter cleared.
  - A transfer in flight is abandoned; no last beat is emitted.
- Config:
  - A write occurs when cfg_valid & cfg_addr==CFG_RES_WR in IDLE. It latches word_end = cfg_data[0 +: CNT_WIDTH] (number of words minus 1; 0 means one word).
  - word_cnt=0, next state LOAD; busy=1 from the next cycle.
  - A CFG_RES_WR write outside IDLE is ignored. Other addresses are ignored.
- Handshakes:
  - Both interfaces transfer on val&rdy at a clk edge.
  - str_res_val, once high, holds with str_res and str_res_last stable until str_res_rdy.
- States:
  - IDLE: res_rdy=0, str_res_val=0, busy=0.
  - LOAD: res_rdy=1. On res_val: capture res_bus into the shift register, beat_cnt=0, go to SHIFT. str_res_val=1 on the cycle after capture, so latency is 1 cycle from res accept to first beat.
  - SHIFT:
    - str_res = shift[STR_RES_WIDTH-1:0]; least-significant slice first.
    - On each beat accepted: shift right by STR_RES_WIDTH and increment beat_cnt.
    - str_res_last=1 only when beat_cnt==RATIO-1 and word_cnt==word_end.
- Final beat of a word (beat_cnt==RATIO-1) with str_res_rdy:
  - If word_cnt==word_end: go to IDLE; busy drops the following cycle.
  - Otherwise increment word_cnt. res_rdy is asserted combinationally in this same cycle (res_rdy = state==LOAD | (state==SHIFT & beat_cnt==RATIO-1 & str_res_rdy & word_cnt!=word_end)).
    - If res_val is high: capture the next word and stay in SHIFT with beat_cnt=0. No bubble, so sustained throughput is 1 beat/cycle.
    - If res_val is low: go to LOAD.
- RATIO==1: every beat is a word final beat; the same rules apply.
- Backpressure: str_res_rdy low stalls all counters; res_rdy then stays 0 in SHIFT.
- Width rules:
  - word_cnt and word_end are CNT_WIDTH bits; maximum transfer is 2^CNT_WIDTH words with no wrap.
  - beat_cnt is clog2(RATIO) bits (min 1).
- Simultaneous events: a config write in the same cycle as the IDLE return from the final beat is ignored, because state is not yet IDLE at that edge.

Decomposition:
- CFG_RES_WR (next free cfg address) goes in the shared cfg_parameters.vh alongside CFG_KER_WR/CFG_KER_RD.
- The state encodings (IDLE/LOAD/SHIFT) stay local.
- One natural sub-module: res_serializer (wide→narrow shift register plus beat counter, with its own val/rdy and last-passthrough). result_str keeps the cfg decode, word counting and FSM.

Test Plan:
- Reset mid-transfer:
  - Stimulus: config word_end=3, push 1 word, drive rst=0 during beat 2.
  - Response: next cycle all outputs 0 and state IDLE. A new config works normally and no str_res_last appears from the old transfer.
- Single word:
  - Stimulus: word_end=0, res_bus=256'h{D,C,B,A} (64-bit slices), str_res_rdy=1.
  - Response: beats A,B,C,D on 4 consecutive cycles starting 1 cycle after accept; last=1 only on D. busy drops 1 cycle after D.
- Back-to-back:
  - Stimulus: word_end=2, res_val always 1, str_res_rdy=1.
  - Response: 12 consecutive valid beats with no gap, res_rdy pulses on beats 4 and 8, and last on beat 12.
- Backpressure:
  - Stimulus: word_end=1, str_res_rdy toggled 1010…
  - Response: str_res stable while stalled, no beats lost or duplicated, 8 beats total, last on the 8th.
- Config while busy:
  - Stimulus: a second CFG_RES_WR with data 7 issued during SHIFT of a word_end=0 transfer.
  - Response: it is ignored; the transfer ends after 4 beats and the block returns to IDLE with res_rdy=0.
- Producer gap:
  - Stimulus: word_end=1, res_val low for 5 cycles after the first word.
  - Response: block sits in LOAD with res_rdy=1, str_res_val=0, busy=1; it resumes on res_val and last is on beat 8.
